// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU: opcodes, ALU codes,
// control-FSM states and instruction field positions.
package cpu_pkg;

    // Instruction opcodes (ir[31:29])
    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_ADD   = 3'd1;
    localparam logic [2:0] OP_SUB   = 3'd2;
    localparam logic [2:0] OP_AND   = 3'd3;
    localparam logic [2:0] OP_OR    = 3'd4;
    localparam logic [2:0] OP_LOAD  = 3'd5;
    localparam logic [2:0] OP_STORE = 3'd6;
    localparam logic [2:0] OP_JMP   = 3'd7;

    // ALU operation select
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // Instruction field positions
    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 29;
    localparam int ADDR_HI = 14;

    // Control FSM states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    // True for the four register-to-register ALU opcodes
    function automatic logic is_alu_op(input logic [2:0] op);
        return (op >= OP_ADD) && (op <= OP_OR);
    endfunction

    // ALU opcodes are laid out so the ALU select is simply opcode-1
    function automatic logic [1:0] alu_op_of(input logic [2:0] op);
        return 2'(op - 3'd1);
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Bus bundle between the control FSM and the instruction memory, decoder,
// register file, ALU and data memory.
interface cpu_ctrl_fsm_if #(
    parameter int ADDR_W = 15,
    parameter int INST_W = 32
);
    // instruction memory handshake
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [INST_W-1:0] imem_rdata;
    // decoder
    logic [INST_W-1:0] ir;
    logic [2:0]        opcode;
    logic [ADDR_W-1:0] addr_fld;
    // register file / ALU
    logic              rf_re;
    logic              alu_en;
    logic [1:0]        alu_op;
    logic              rf_we;
    logic              rf_wsel;
    // data memory handshake
    logic              dmem_req;
    logic              dmem_we;
    logic              dmem_ack;

    modport master (
        output imem_req, imem_addr, ir, rf_re, alu_en, alu_op,
               rf_we, rf_wsel, dmem_req, dmem_we,
        input  imem_ack, imem_rdata, opcode, addr_fld, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, ir, rf_re, alu_en, alu_op,
               rf_we, rf_wsel, dmem_req, dmem_we,
        output imem_ack, imem_rdata, opcode, addr_fld, dmem_ack
    );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control unit: fetches into IR, sequences decode, execute,
// memory and write-back, and owns the program counter.
module cpu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 15,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               halt_req,
    cpu_ctrl_fsm_if.master     bus,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy
);

    state_t            state;
    state_t            state_nxt;
    state_t            retire_state;
    logic [INST_W-1:0] ir;
    logic              halt_seen;

    // A halt seen at any point of this instruction, including the retiring
    // cycle itself, sends the FSM back to IDLE instead of the next fetch.
    assign retire_state = (halt_seen || halt_req) ? S_IDLE : S_FETCH;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // PC, instruction register and sticky halt flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            ir        <= '0;
            halt_seen <= 1'b0;
        end else begin
            halt_seen <= (state != S_IDLE) && (halt_seen || halt_req);
            if (state == S_FETCH && bus.imem_ack) begin
                ir <= bus.imem_rdata;
                pc <= pc + 1'b1;
            end else if (state == S_EXEC && bus.opcode == OP_JMP) begin
                pc <= bus.addr_fld;
            end
        end
    end

    // Next-state logic; acks only matter in the state that raised the request
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
            S_FETCH:  if (bus.imem_ack) state_nxt = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_JMP: state_nxt = S_EXEC;
                    OP_LOAD, OP_STORE:                     state_nxt = S_MEM;
                    default:                               state_nxt = retire_state;
                endcase
            end
            S_EXEC:   state_nxt = (bus.opcode == OP_JMP) ? retire_state : S_WB;
            S_MEM: begin
                if (bus.dmem_ack) begin
                    state_nxt = (bus.opcode == OP_LOAD) ? S_WB : retire_state;
                end
            end
            S_WB:     state_nxt = retire_state;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Control outputs decoded from the current state and opcode
    always_comb begin
        bus.imem_req = 1'b0;
        bus.rf_re    = 1'b0;
        bus.alu_en   = 1'b0;
        bus.alu_op   = ALU_ADD;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        bus.rf_we    = 1'b0;
        bus.rf_wsel  = 1'b0;
        case (state)
            S_FETCH:  bus.imem_req = 1'b1;
            S_DECODE: bus.rf_re = is_alu_op(bus.opcode) || (bus.opcode == OP_STORE);
            S_EXEC: begin
                if (is_alu_op(bus.opcode)) begin
                    bus.alu_en = 1'b1;
                    bus.alu_op = alu_op_of(bus.opcode);
                end
            end
            S_MEM: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = (bus.opcode == OP_STORE);
            end
            S_WB: begin
                bus.rf_we   = 1'b1;
                bus.rf_wsel = (bus.opcode == OP_LOAD);
            end
            default: ;
        endcase
    end

    assign bus.imem_addr = pc;
    assign bus.ir        = ir;
    assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: directed scenarios followed by
// randomized instruction streams against a per-instruction reference model.
module tb_cpu_ctrl_fsm;

    localparam int ADDR_W = 15;
    localparam int INST_W = 32;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              halt_req;
    logic [ADDR_W-1:0] pc;
    logic              busy;

    cpu_ctrl_fsm_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

    cpu_ctrl_fsm #(.ADDR_W(ADDR_W), .INST_W(INST_W), .RESET_PC(15'd0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .halt_req (halt_req),
        .bus      (bus),
        .pc       (pc),
        .busy     (busy)
    );

    // External decoder stand-in
    assign bus.opcode   = bus.ir[31:29];
    assign bus.addr_fld = bus.ir[14:0];

    // All control outputs packed: {imem_req, rf_re, alu_en, alu_op, dmem_req, dmem_we, rf_we, rf_wsel, busy}
    logic [9:0] ctrl_now;
    assign ctrl_now = {bus.imem_req, bus.rf_re, bus.alu_en, bus.alu_op,
                       bus.dmem_req, bus.dmem_we, bus.rf_we, bus.rf_wsel, busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    int unsigned m_pc   = 0;
    bit          m_halt = 0;
    int          cyc    = 0;
    int          halt_at = -1;
    bit          noise  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [9:0] cv(input logic ireq, rre, aen, input logic [1:0] aop,
                                      input logic dreq, dwe, rwe, rws, bsy);
        return {ireq, rre, aen, aop, dreq, dwe, rwe, rws, bsy};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_cycle(input string tag, input logic [9:0] ec);
        check_val({tag, ".ctrl"}, {22'd0, ctrl_now}, {22'd0, ec});
        check_val({tag, ".pc"}, {17'd0, pc}, m_pc);
        if (ec[9]) check_val({tag, ".imem_addr"}, {17'd0, bus.imem_addr}, m_pc);
    endtask

    // Per-cycle side stimulus: optional halt pulse and ignored start noise
    task automatic drive_side();
        halt_req = (cyc == halt_at);
        if (halt_req) m_halt = 1'b1;
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        cyc++;
    endtask

    task automatic expect_idle(input int n);
        for (int i = 0; i < n; i++) begin
            expect_cycle("idle", 10'd0);
            start = 1'b0; halt_req = 1'b0;
            tick();
        end
    endtask

    task automatic do_start();
        expect_cycle("pre_start", 10'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Run one instruction through the DUT and check every cycle of it.
    // fw/mw: wait cycles before imem/dmem ack; h_at: cycle to pulse halt_req;
    // spur: ack the other memory while it is not requested; rst_mem: MEM cycle to reset in.
    task automatic run_instr(input logic [31:0] w, input int fw, input int mw, input int h_at,
                             input bit spur, input bit nz, input int rst_mem, output bit ended_idle);
        logic [2:0] op;
        bit         alu;
        op = w[31:29];
        alu = (op >= 3'd1) && (op <= 3'd4);
        cyc = 0; halt_at = h_at; noise = nz; ended_idle = 1'b0;
        for (int i = 0; i <= fw; i++) begin
            expect_cycle("fetch", cv(1, 0, 0, 2'd0, 0, 0, 0, 0, 1));
            bus.imem_ack   = (i == fw);
            bus.imem_rdata = (i == fw) ? w : $urandom();
            bus.dmem_ack   = spur;
            drive_side();
            tick();
        end
        bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
        m_pc = (m_pc + 1) % (1 << ADDR_W);
        check_val("ir", bus.ir, w);
        expect_cycle("decode", cv(0, alu || op == 3'd6, 0, 2'd0, 0, 0, 0, 0, 1));
        bus.imem_ack = spur;
        drive_side();
        tick();
        bus.imem_ack = 1'b0;
        if (alu) begin
            expect_cycle("exec", cv(0, 0, 1, 2'(op - 3'd1), 0, 0, 0, 0, 1));
            drive_side(); tick();
            expect_cycle("wb_alu", cv(0, 0, 0, 2'd0, 0, 0, 1, 0, 1));
            drive_side(); tick();
        end else if (op == 3'd7) begin
            expect_cycle("exec_jmp", cv(0, 0, 0, 2'd0, 0, 0, 0, 0, 1));
            drive_side(); tick();
            m_pc = w[14:0];
        end else if (op == 3'd5 || op == 3'd6) begin
            for (int i = 0; i <= mw; i++) begin
                expect_cycle("mem", cv(0, 0, 0, 2'd0, 1, op == 3'd6, 0, 0, 1));
                if (i == rst_mem) begin
                    halt_req = 1'b0; start = 1'b0;
                    rst_n = 1'b0;
                    #1;
                    m_pc = 0; m_halt = 1'b0;
                    check_val("rst_async.ctrl", {22'd0, ctrl_now}, 32'd0);
                    check_val("rst_async.pc", {17'd0, pc}, 32'd0);
                    check_val("rst_async.ir", bus.ir, 32'd0);
                    bus.dmem_ack = 1'b0;
                    tick();
                    expect_cycle("rst_held", 10'd0);
                    rst_n = 1'b1;
                    expect_idle(3);
                    ended_idle = 1'b1;
                    return;
                end
                bus.dmem_ack = (i == mw);
                bus.imem_ack = spur;
                drive_side();
                tick();
            end
            bus.dmem_ack = 1'b0; bus.imem_ack = 1'b0;
            if (op == 3'd5) begin
                expect_cycle("wb_load", cv(0, 0, 0, 2'd0, 0, 0, 1, 1, 1));
                drive_side(); tick();
            end
        end
        halt_req = 1'b0; start = 1'b0; halt_at = -1;
        if (m_halt) begin
            expect_idle(3);
            m_halt = 1'b0;
            ended_idle = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit idle;
        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.dmem_ack = 1'b0;
        @(negedge clk);
        check_val("reset.ctrl", {22'd0, ctrl_now}, 32'd0);
        check_val("reset.pc", {17'd0, pc}, 32'd0);
        check_val("reset.ir", bus.ir, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = 0;
        expect_idle(2);

        do_start();
        run_instr(32'h2000_0C21, 0, 0, -1, 0, 0, -1, idle);   // ADD, zero-wait
        run_instr(32'hA000_1234, 0, 2, -1, 0, 0, -1, idle);   // LOAD, 3-cycle dmem
        for (int i = 0; i < 3; i++) run_instr(32'h0000_0000, 0, 0, -1, 0, 0, -1, idle);
        run_instr(32'hE000_7FFF, 0, 0, -1, 0, 0, -1, idle);   // JMP at pc=5
        run_instr(32'h0000_0000, 1, 0, -1, 0, 0, -1, idle);   // fetch at 0x7FFF, wraps
        run_instr(32'hC000_0010, 1, 1, -1, 1, 0, -1, idle);   // STORE, spurious acks
        run_instr(32'h2000_0C21, 2, 0, 1, 0, 0, -1, idle);    // halt pulse during fetch
        check_val("halt_idle", {31'd0, idle}, 32'd1);
        do_start();
        run_instr(32'hA000_0042, 0, 4, -1, 0, 0, 2, idle);    // reset mid-MEM
        do_start();

        for (int n = 0; n < 300; n++) begin
            logic [31:0] w;
            int          h;
            w = $urandom();
            h = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : -1;
            run_instr(w, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), h,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, idle);
            if (idle) do_start();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
- Multi-cycle control unit for the 32-bit, 8-opcode CPU.
- Fetches instructions over an instruction-memory handshake and holds each one in an instruction register (IR).
- Feeds the IR to the instruction decoder and takes back its 3-bit opcode.
- Sequences the register file, ALU, data memory and PC through FETCH/DECODE/EXEC/MEM/WB states.

Parameters:
- ADDR_W, 15, PC and memory address width; matches inst[14:0] addr field.
- INST_W, 32, instruction width.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  leave IDLE and begin fetching at the current PC.
- halt_req  in  1  stop after the current instruction retires.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  ADDR_W  fetch address (= pc).
- imem_ack  in  1  fetch complete; imem_rdata is valid this cycle.
- imem_rdata  in  INST_W  fetched instruction.
- ir  out  INST_W  latched instruction, drives the decoder input.
- opcode  in  3  decoder output (ir[31:29]).
- addr_fld  in  ADDR_W  decoder addr output (ir[14:0]).
- rf_re  out  1  register file read of reg_addr_1/2 (and reg_addr_0 for STORE).
- alu_en  out  1  ALU result valid/capture.
- alu_op  out  2  00 ADD, 01 SUB, 10 AND, 11 OR.
- dmem_req  out  1  data memory request; address = addr_fld.
- dmem_we  out  1  1 = write (STORE), 0 = read (LOAD).
- dmem_ack  in  1  data access complete.
- rf_we  out  1  write back to reg_addr_0.
- rf_wsel  out  1  write-data select: 0 = ALU, 1 = memory.
- pc  out  ADDR_W  program counter.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Opcodes: 000 NOP, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 LOAD, 110 STORE, 111 JMP.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB. Encoding is one-hot or binary; the choice is free.
- Reset (async, any state): state=IDLE, pc=RESET_PC, ir=0, all control outputs 0.
- IDLE: all outputs 0. start=1 -> FETCH next cycle. start in any other state is ignored.
- FETCH:
  - imem_req=1, held until imem_ack is sampled 1.
  - On ack: ir<=imem_rdata, pc<=pc+1 (wraps 2^ADDR_W-1 -> 0), go to DECODE.
  - Zero-wait memory (ack in the first FETCH cycle) gives a 1-cycle fetch.
- DECODE:
  - Registered opcode is valid; rf_re=1 for ALU ops and STORE.
  - Next state: NOP -> RETIRE; ADD..OR -> EXEC; LOAD/STORE -> MEM; JMP -> EXEC.
- EXEC:
  - ALU ops: alu_en=1, alu_op=opcode-1, then WB.
  - JMP: pc<=addr_fld, no alu_en, then RETIRE.
- MEM:
  - dmem_req=1, dmem_we=(opcode==STORE), held until dmem_ack.
  - On ack: LOAD -> WB; STORE -> RETIRE.
- WB: rf_we=1 for exactly one cycle; rf_wsel=1 for LOAD, 0 for ALU ops; then RETIRE.
- RETIRE (a transition, not a state):
  - Go to IDLE if halt_req was sampled 1 at any point since the instruction's FETCH began (sticky flag, cleared in IDLE); otherwise go to FETCH.
- halt_req never aborts an in-flight handshake.
- imem_ack/dmem_ack arriving while the corresponding req=0 are ignored.
- Zero-wait latencies (cycles): NOP 2, JMP 3, STORE 3, ALU 4, LOAD 4.
- No two control outputs other than the listed pairs (rf_re only in DECODE; rf_we only in WB) are ever high in the same cycle.

Decomposition:
- Shared package cpu_pkg:
  - opcode localparams (OP_NOP..OP_JMP);
  - ALU op codes;
  - state enum;
  - field positions (OPC_HI=31, OPC_LO=29, ADDR_HI=14).
- Single module; no sub-module.
- The decoder stays external and is instantiated beside this block in the CPU top.

Test Plan:
- Reset mid-MEM with dmem_req=1 -> next edge all outputs 0, pc=0, state IDLE; remains idle until start.
- start, zero-wait memory, imem_rdata=0x2000_0C21 (ADD) -> imem_req cycle 1, rf_re cycle 2, alu_en + alu_op=00 cycle 3, rf_we + rf_wsel=0 cycle 4, pc=1, imem_req again cycle 5.
- LOAD 0xA000_1234 with dmem_ack delayed 3 cycles -> dmem_req=1 and dmem_we=0 for 3 cycles at addr 0x1234, then rf_we=1 with rf_wsel=1 for one cycle.
- JMP 0xE000_7FFF at pc=5 -> pc=0x7FFF after EXEC; next fetch at 0x7FFF; after that ack pc wraps to 0x0000.
- STORE 0xC000_0010 -> dmem_req=1, dmem_we=1, no rf_we; spurious dmem_ack pulsed in the preceding FETCH has no effect.
- halt_req pulsed 1 cycle during FETCH of an ADD -> ADD completes, including rf_we, then IDLE with busy=0 and imem_req not reasserted.
